// File: rtl/hazard_unit_pkg.sv
// Purpose: shared CPU definitions for the hazard unit (bypass codes, divide FSM states).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_unit_pkg;

   // Bypass select codes for the EX-stage operand muxes
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   // Cycles a divide occupies EX unless overridden
   localparam int DIV_CYCLES_DEF = 32;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

   // The younger producer (MEM) wins over the older one (WB)
   function automatic logic [1:0] fwd_sel(input logic hit_mem, input logic hit_wb);
      logic [1:0] sel;
      sel = FWD_RF;
      if (hit_mem) begin
         sel = FWD_MEM;
      end else if (hit_wb) begin
         sel = FWD_WB;
      end
      return sel;
   endfunction

endpackage

// File: rtl/hazard_unit_div_stall_fsm.sv
// Purpose: tracks a multi-cycle divide in EX and freezes the pipeline while it runs.
// Latency: busy one cycle after divstart_i; done pulse DIV_CYCLES cycles after divstart_i.
// Backpressure: divstall_o freezes every stage during BUSY; released in DONE.
module div_stall_fsm
   import hazard_unit_pkg::*;
#(
   parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic divstart_i,
   output logic divbusy_o,
   output logic divdone_o,
   output logic divstall_o
);

   // BUSY runs from DIV_CYCLES-2 down to 0 inclusive, then one DONE cycle
   localparam logic [5:0] CNT_LOAD = 6'(DIV_CYCLES - 2);

   div_state_e state_q, state_d;
   logic [5:0] cnt_q, cnt_d;

   // State and counter registers; reset aborts any divide in flight
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= DIV_IDLE;
         cnt_q   <= 6'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state, counter update and decoded outputs
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      divbusy_o  = 1'b0;
      divdone_o  = 1'b0;
      divstall_o = 1'b0;
      case (state_q)
         DIV_IDLE: begin
            if (divstart_i) begin
               state_d = DIV_BUSY;
               cnt_d   = CNT_LOAD;
            end
         end
         DIV_BUSY: begin
            divbusy_o  = 1'b1;
            divstall_o = 1'b1;
            if (cnt_q == 6'd0) begin
               state_d = DIV_DONE;
            end else begin
               cnt_d = cnt_q - 6'd1;
            end
         end
         DIV_DONE: begin
            // A divstart seen here belongs to the divide that is leaving EX
            divbusy_o = 1'b1;
            divdone_o = 1'b1;
            state_d   = DIV_IDLE;
         end
         default: begin
            state_d = DIV_IDLE;
            cnt_d   = 6'd0;
         end
      endcase
   end

endmodule

// File: rtl/hazard_unit.sv
// Purpose: pipeline bypass selection and stall/flush generation; DIV_STALL_EN adds multi-cycle divide stalls.
// Latency: all bypass/stall outputs combinational; divide tracking is registered.
// Backpressure: stallF/D/E/M freeze stages, flushE bubbles EX; divide stall overrides data-hazard stalls.
module hazard_unit
   import hazard_unit_pkg::*;
#(
   parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] rsD,
   input  logic [4:0] rtD,
   input  logic [4:0] rsE,
   input  logic [4:0] rtE,
   input  logic [4:0] writeregE,
   input  logic [4:0] writeregM,
   input  logic [4:0] writeregW,
   input  logic       regwriteE,
   input  logic       regwriteM,
   input  logic       regwriteW,
   input  logic       memtoregE,
   input  logic       memtoregM,
   input  logic       branchD,
   input  logic       jrD,
   input  logic [1:0] hregwriteE,
   input  logic [1:0] hregwriteM,
   input  logic [1:0] hregwriteW,
   input  logic       divstartE,
   input  logic       mfhiD,
   input  logic       mfloD,
   output logic       forwardaD,
   output logic       forwardbD,
   output logic [1:0] forwardaE,
   output logic [1:0] forwardbE,
   output logic [1:0] forwardhiE,
   output logic [1:0] forwardloE,
   output logic       stallF,
   output logic       stallD,
   output logic       stallE,
   output logic       stallM,
   output logic       flushE,
   output logic       divbusy,
   output logic       divdone
);

   logic [1:0] fwd_a_e, fwd_b_e, fwd_hi_e, fwd_lo_e;
   logic       fwd_a_d, fwd_b_d;
   logic       lw_stall, br_stall, mf_stall, haz_stall, div_stall;
   logic       br_e_hit, br_m_hit;

   // EX and ID bypass selection; register 0 is never forwarded for GPRs
   always_comb begin
      fwd_a_e  = fwd_sel((rsE != 5'd0) && (rsE == writeregM) && regwriteM,
                         (rsE != 5'd0) && (rsE == writeregW) && regwriteW);
      fwd_b_e  = fwd_sel((rtE != 5'd0) && (rtE == writeregM) && regwriteM,
                         (rtE != 5'd0) && (rtE == writeregW) && regwriteW);
      fwd_hi_e = fwd_sel(hregwriteM[1], hregwriteW[1]);
      fwd_lo_e = fwd_sel(hregwriteM[0], hregwriteW[0]);
      fwd_a_d  = (rsD != 5'd0) && (rsD == writeregM) && regwriteM;
      fwd_b_d  = (rtD != 5'd0) && (rtD == writeregM) && regwriteM;
   end

   // Data hazards: load-use, and branch/jr operands still in flight (jr only reads rs)
   always_comb begin
      lw_stall  = memtoregE && ((rtE == rsD) || (rtE == rtD));
      br_e_hit  = regwriteE && ((writeregE == rsD) || (branchD && (writeregE == rtD)));
      br_m_hit  = memtoregM && ((writeregM == rsD) || (branchD && (writeregM == rtD)));
      br_stall  = (branchD || jrD) && (br_e_hit || br_m_hit);
      haz_stall = lw_stall || br_stall || mf_stall;
   end

`ifdef DIV_STALL_EN
   div_stall_fsm #(
      .DIV_CYCLES (DIV_CYCLES)
   ) u_div_fsm (
      .clk        (clk),
      .rst        (rst),
      .divstart_i (divstartE),
      .divbusy_o  (divbusy),
      .divdone_o  (divdone),
      .divstall_o (div_stall)
   );

   // HI/LO readers wait until the divide result is written back
   assign mf_stall = (mfhiD || mfloD) && divbusy;

   logic unused_inputs;
   assign unused_inputs = ^hregwriteE;
`else
   // Single-cycle divider: nothing to track
   assign divbusy   = 1'b0;
   assign divdone   = 1'b0;
   assign div_stall = 1'b0;
   assign mf_stall  = 1'b0;

   logic unused_inputs;
   assign unused_inputs = ^{hregwriteE, divstartE, mfhiD, mfloD, 6'(DIV_CYCLES)};
`endif

   // Output stage: reset forces every control to its safe value; divide stall wins and never flushes
   always_comb begin
      forwardaE  = rst ? fwd_a_e  : FWD_RF;
      forwardbE  = rst ? fwd_b_e  : FWD_RF;
      forwardhiE = rst ? fwd_hi_e : FWD_RF;
      forwardloE = rst ? fwd_lo_e : FWD_RF;
      forwardaD  = rst && fwd_a_d;
      forwardbD  = rst && fwd_b_d;
      stallF     = rst && (div_stall || haz_stall);
      stallD     = rst && (div_stall || haz_stall);
      stallE     = rst && div_stall;
      stallM     = rst && div_stall;
      flushE     = rst && haz_stall && !div_stall;
   end

endmodule
